// File: rtl/apu_pkg.sv
// Shared noise-channel constants: register addresses, frame-sequencer step masks, length limits.
// Latency: n/a (declarations only).  Backpressure: n/a.
package apu_pkg;

    typedef enum logic [1:0] {
        REG_NR41 = 2'd0,
        REG_NR42 = 2'd1,
        REG_NR43 = 2'd2,
        REG_NR44 = 2'd3
    } reg_addr_e;

    // Bit n set means the tick fires when the sequencer is at step n.
    localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
    localparam logic [2:0] ENV_STEP    = 3'd7;

    localparam int unsigned LENGTH_MAX = 64;
    localparam int unsigned LENGTH_W   = 7;

    // NR41 holds the elapsed count; the counter runs down the remainder.
    function automatic logic [LENGTH_W-1:0] length_load(input logic [5:0] val);
        return LENGTH_W'(LENGTH_MAX) - {1'b0, val};
    endfunction

endpackage

// File: rtl/noise_length_timer.sv
// Noise length counter and channel_on status; load > trigger reload > decrement.
// Latency: 1 cycle from load/trigger/length_tick to state.  Backpressure: none.
module noise_length_timer
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       load,
    input  logic [5:0] load_value,
    input  logic       length_tick,
    input  logic       length_en,
    input  logic       trigger,
    input  logic       dac_on,
    output logic       channel_on
);

    logic [LENGTH_W-1:0] length_q;
    logic [LENGTH_W-1:0] length_dec;
    logic [LENGTH_W-1:0] length_nxt;
    logic                on_q;
    logic                on_nxt;
    logic                dec_hit;

    always_comb begin
        dec_hit    = 1'b0;
        length_dec = length_q;
        length_nxt = length_q;
        on_nxt     = on_q;

        if (length_tick && length_en && (length_q != '0)) begin
            length_dec = length_q - LENGTH_W'(1);
            dec_hit    = (length_q == LENGTH_W'(1));
        end

        length_nxt = length_dec;
        // Trigger is evaluated after the decrement so it also wins over a decrement to zero.
        if (trigger && (length_dec == '0)) begin
            length_nxt = LENGTH_W'(LENGTH_MAX);
        end
        if (load) begin
            length_nxt = length_load(load_value);
        end

        if (trigger) begin
            on_nxt = 1'b1;
        end else if (dec_hit) begin
            on_nxt = 1'b0;
        end
        if (!dac_on) begin
            on_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            length_q <= '0;
            on_q     <= 1'b0;
        end else if (!enable) begin
            length_q <= '0;
            on_q     <= 1'b0;
        end else begin
            length_q <= length_nxt;
            on_q     <= on_nxt;
        end
    end

    // DAC off masks the status immediately, before the register itself clears.
    assign channel_on = on_q & dac_on;

endmodule

// File: rtl/noise_sequencer.sv
// Noise channel frame sequencer, register file and trigger; sweep decode built only with NOISE_SEQ_SWEEP_EN.
// Latency: ticks, trigger and register writes visible 1 cycle after the strobe.  Backpressure: none.
module noise_sequencer
    import apu_pkg::*;
(
    input  logic       system_clock,
    input  logic       reset,
    input  logic       tick_512,
    input  logic       apu_enable,
    input  logic       reg_wr,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic [7:0] NR41,
    output logic [7:0] NR42,
    output logic [7:0] NR43,
    output logic [7:0] NR44,
    output logic       trigger,
    output logic       length_tick,
    output logic       envelope_tick,
    output logic       sweep_tick,
    output logic [2:0] step,
    output logic       channel_on
);

    reg_addr_e addr;
    logic      wr_en;
    logic      nr41_load;

    assign addr      = reg_addr_e'(reg_addr);
    assign wr_en     = reg_wr & apu_enable;
    assign nr41_load = wr_en & (addr == REG_NR41);

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            step          <= '0;
            length_tick   <= 1'b0;
            envelope_tick <= 1'b0;
        end else if (!apu_enable) begin
            step          <= '0;
            length_tick   <= 1'b0;
            envelope_tick <= 1'b0;
        end else begin
            // Decode uses the step value before this tick's increment.
            length_tick   <= tick_512 & LEN_STEPS[step];
            envelope_tick <= tick_512 & (step == ENV_STEP);
            if (tick_512) begin
                step <= step + 3'd1;
            end
        end
    end

`ifdef NOISE_SEQ_SWEEP_EN
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            sweep_tick <= 1'b0;
        end else if (!apu_enable) begin
            sweep_tick <= 1'b0;
        end else begin
            sweep_tick <= tick_512 & SWEEP_STEPS[step];
        end
    end
`else
    assign sweep_tick = 1'b0;
`endif

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            NR41    <= '0;
            NR42    <= '0;
            NR43    <= '0;
            NR44    <= '0;
            trigger <= 1'b0;
        end else if (!apu_enable) begin
            NR41    <= '0;
            NR42    <= '0;
            NR43    <= '0;
            NR44    <= '0;
            trigger <= 1'b0;
        end else begin
            trigger <= wr_en & (addr == REG_NR44) & reg_wdata[7];
            if (reg_wr) begin
                unique case (addr)
                    REG_NR41: NR41 <= reg_wdata;
                    REG_NR42: NR42 <= reg_wdata;
                    REG_NR43: NR43 <= reg_wdata;
                    REG_NR44: NR44 <= {1'b0, reg_wdata[6:0]};
                endcase
            end
        end
    end

    noise_length_timer u_length (
        .clk         (system_clock),
        .rst         (reset),
        .enable      (apu_enable),
        .load        (nr41_load),
        .load_value  (reg_wdata[5:0]),
        .length_tick (length_tick),
        .length_en   (NR44[6]),
        .trigger     (trigger),
        .dac_on      (|NR42[7:3]),
        .channel_on  (channel_on)
    );

endmodule

// File: tb/tb_noise_sequencer.sv
// Scoreboard bench for noise_sequencer: a behavioural model queues the expected outputs per cycle,
// and a negedge monitor pops and compares them against the DUT.
module tb_noise_sequencer;

    logic       system_clock = 1'b0;
    logic       reset        = 1'b1;
    logic       tick_512     = 1'b0;
    logic       apu_enable   = 1'b0;
    logic       reg_wr       = 1'b0;
    logic [1:0] reg_addr     = 2'd0;
    logic [7:0] reg_wdata    = 8'd0;
    logic [7:0] NR41, NR42, NR43, NR44;
    logic       trigger, length_tick, envelope_tick, sweep_tick, channel_on;
    logic [2:0] step;

    noise_sequencer dut (
        .system_clock  (system_clock),
        .reset         (reset),
        .tick_512      (tick_512),
        .apu_enable    (apu_enable),
        .reg_wr        (reg_wr),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .NR41          (NR41),
        .NR42          (NR42),
        .NR43          (NR43),
        .NR44          (NR44),
        .trigger       (trigger),
        .length_tick   (length_tick),
        .envelope_tick (envelope_tick),
        .sweep_tick    (sweep_tick),
        .step          (step),
        .channel_on    (channel_on)
    );

    always #5 system_clock = ~system_clock;

    typedef struct packed {
        logic [2:0] step;
        logic       lt;
        logic       st;
        logic       et;
        logic       trig;
        logic       on;
        logic [6:0] len;
        logic [7:0] r41;
        logic [7:0] r42;
        logic [7:0] r43;
        logic [7:0] r44;
    } snap_t;

    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference state: what the outputs should show after the most recent clock edge.
    int         m_step;
    int         m_len;
    bit         m_lt, m_st, m_et, m_trig, m_on;
    logic [7:0] m_reg [4];

    function automatic snap_t model_snap();
        snap_t s;
        s.step = 3'(m_step);
        s.lt   = m_lt;
        s.st   = m_st;
        s.et   = m_et;
        s.trig = m_trig;
        s.on   = m_on && (m_reg[1][7:3] != 5'd0);
        s.len  = 7'(m_len);
        s.r41  = m_reg[0];
        s.r42  = m_reg[1];
        s.r43  = m_reg[2];
        s.r44  = m_reg[3];
        return s;
    endfunction

    task automatic model_reset();
        m_step = 0; m_len = 0;
        m_lt = 0; m_st = 0; m_et = 0; m_trig = 0; m_on = 0;
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    endtask

    task automatic model_edge(input bit tk, input bit en, input bit wr,
                              input logic [1:0] a, input logic [7:0] d);
        int nl;
        bit no;
        bit dec;
        if (!en) begin
            model_reset();
        end else begin
            dec = m_lt && m_reg[3][6] && (m_len > 0);
            nl  = dec ? m_len - 1 : m_len;
            no  = m_on;
            if (dec && nl == 0) no = 0;
            if (m_trig) begin
                no = 1;
                if (nl == 0) nl = 64;
            end
            if (wr && a == 2'd0) nl = 64 - (int'(d) % 64);
            if (m_reg[1][7:3] == 5'd0) no = 0;
            m_len = nl;
            m_on  = no;

            m_lt = tk && (m_step % 2 == 0);
`ifdef NOISE_SEQ_SWEEP_EN
            m_st = tk && (m_step == 2 || m_step == 6);
`else
            m_st = 0;
`endif
            m_et = tk && (m_step == 7);
            if (tk) m_step = (m_step + 1) % 8;

            m_trig = wr && (a == 2'd3) && d[7];
            if (wr) m_reg[a] = (a == 2'd3) ? (d & 8'h7F) : d;
        end
    endtask

    // Called just after a rising edge: queue the current expectation, then drive the next inputs.
    task automatic cycle(input bit tk, input bit en, input bit wr,
                         input logic [1:0] a, input logic [7:0] d);
        exp_q.push_back(model_snap());
        tick_512   = tk;
        apu_enable = en;
        reg_wr     = wr;
        reg_addr   = a;
        reg_wdata  = d;
        model_edge(tk, en, wr, a, d);
        @(posedge system_clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 2'd0, 8'h00);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        cycle(0, 1, 1, a, d);
    endtask

    // Reset is raised mid-cycle so the very next sample must already show cleared outputs.
    task automatic do_reset();
        reset    = 1'b1;
        tick_512 = 1'b0;
        reg_wr   = 1'b0;
        model_reset();
        exp_q.push_back(model_snap());
        @(posedge system_clock);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge system_clock) begin
        snap_t e;
        snap_t act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act.step = step;
            act.lt   = length_tick;
            act.st   = sweep_tick;
            act.et   = envelope_tick;
            act.trig = trigger;
            act.on   = channel_on;
            act.len  = dut.u_length.length_q;
            act.r41  = NR41;
            act.r42  = NR42;
            act.r43  = NR43;
            act.r44  = NR44;
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL outputs @%0t: got step=%0d lt=%b st=%b et=%b trig=%b on=%b len=%0d nr=%h/%h/%h/%h, expected step=%0d lt=%b st=%b et=%b trig=%b on=%b len=%0d nr=%h/%h/%h/%h",
                         $time, act.step, act.lt, act.st, act.et, act.trig, act.on, act.len,
                         act.r41, act.r42, act.r43, act.r44,
                         e.step, e.lt, e.st, e.et, e.trig, e.on, e.len, e.r41, e.r42, e.r43, e.r44);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit tk, en, wr;
        logic [1:0] a;
        logic [7:0] d;

        model_reset();
        repeat (2) @(posedge system_clock);
        #1;
        do_reset();

        // Eight ticks from reset: step walks 1..7,0 with the decoded pulses.
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 0, 2'd0, 8'h00);
            idle(1);
        end
        if (step !== 3'd0) begin
            n_bad++;
            $display("FAIL directed: step after 8 ticks = %0d, expected 0", step);
        end

        // Length countdown from 2 with a triggered channel.
        wr_reg(2'd1, 8'hF0);
        wr_reg(2'd0, 8'h3E);
        wr_reg(2'd3, 8'hC0);
        if (NR44 !== 8'h40) begin
            n_bad++;
            $display("FAIL directed: NR44 = %h, expected 40", NR44);
        end
        if (trigger !== 1'b1) begin
            n_bad++;
            $display("FAIL directed: trigger not pulsed after NR44 write");
        end
        idle(3);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 0, 2'd0, 8'h00);
            idle(1);
        end

        // DAC off: trigger still pulses, channel stays off.
        wr_reg(2'd1, 8'h00);
        wr_reg(2'd3, 8'h80);
        if (trigger !== 1'b1) begin
            n_bad++;
            $display("FAIL directed: trigger not pulsed with DAC off");
        end
        if (channel_on !== 1'b0) begin
            n_bad++;
            $display("FAIL directed: channel_on set with DAC off");
        end
        idle(3);
        wr_reg(2'd1, 8'hF0);

        // Trigger lands on the same edge as the decrement to zero.
        wr_reg(2'd0, 8'h3F);
        wr_reg(2'd3, 8'hC0);
        idle(2);
        while (m_step % 2 != 0) begin
            cycle(1, 1, 0, 2'd0, 8'h00);
            idle(1);
        end
        cycle(1, 1, 1, 2'd3, 8'hC0);
        idle(3);

        // Drop enable at step 5; writes and ticks while disabled are ignored.
        while (m_step != 5) begin
            cycle(1, 1, 0, 2'd0, 8'h00);
            idle(1);
        end
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 2'(i), 8'hFF);
        if (step !== 3'd0 || channel_on !== 1'b0 || NR44 !== 8'h00 || trigger !== 1'b0) begin
            n_bad++;
            $display("FAIL directed: outputs not cleared while disabled (step=%0d on=%b NR44=%h trig=%b)",
                     step, channel_on, NR44, trigger);
        end
        idle(1);
        cycle(1, 1, 0, 2'd0, 8'h00);
        idle(2);

        // Reset while trigger and length_tick are mid-pulse.
        wr_reg(2'd1, 8'hF0);
        cycle(1, 1, 1, 2'd3, 8'hC0);
        do_reset();
        cycle(1, 1, 0, 2'd0, 8'h00);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            tk = ($urandom_range(0, 3) == 0);
            en = ($urandom_range(0, 59) != 0);
            wr = ($urandom_range(0, 5) == 0);
            a  = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            if (wr && a == 2'd1 && $urandom_range(0, 3) != 0) d[7] = 1'b1;
            if (wr && a == 2'd0) d[5:4] = 2'b11;
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle(tk, en, wr, a, d);
        end

        idle(2);
        @(negedge system_clock);
        @(negedge system_clock);
        if (n_cmp == 0) begin
            n_bad++;
            $display("FAIL directed: no scoreboard comparisons performed");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/noise_sequencer.md
NOISE_SEQUENCER -- requirements
Module: noise_sequencer

Interface
REQ-001 system_clock  in  1  single clock; all state on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 tick_512  in  1  one-cycle 512 Hz strobe.
REQ-004 apu_enable  in  1  master enable; low forces power-off state.
REQ-005 reg_wr  in  1  one-cycle register write strobe.
REQ-006 reg_addr  in  2  0=NR41, 1=NR42, 2=NR43, 3=NR44.
REQ-007 reg_wdata  in  8  write data.
REQ-008 NR41, NR42, NR43, NR44  out  8 each  held register images for the noise datapath.
REQ-009 trigger  out  1  one-cycle channel restart pulse.
REQ-010 length_tick, envelope_tick, sweep_tick  out  1 each  one-cycle frame-sequencer pulses.
REQ-011 step  out  3  current frame-sequencer step.
REQ-012 channel_on  out  1  channel-active status.

Function
REQ-013 The block SHALL advance step by 1 on each tick_512 while apu_enable=1, wrapping 7->0.
REQ-014 The block SHALL decode step before increment: length_tick at steps 0/2/4/6, sweep_tick at steps 2/6, envelope_tick at step 7, asserted the cycle after tick_512 (latency 1).
REQ-015 A reg_wr SHALL update the addressed register on the next edge (latency 1).
REQ-016 A write to NR44 with bit7=1 SHALL pulse trigger for exactly one cycle, one cycle after the write.
REQ-017 Stored NR44 bit7 SHALL always read 0.
REQ-018 A write to NR41 SHALL load the 7-bit length_remaining with 64 - reg_wdata[5:0], giving a range of 1..64.
REQ-019 On length_tick, with NR44[6]=1 and length_remaining non-zero, length_remaining SHALL decrement.
REQ-020 A decrement reaching 0 SHALL clear channel_on on the same edge.
REQ-021 A trigger SHALL set channel_on and SHALL reload length_remaining to 64 if it is 0.
REQ-022 channel_on SHALL be forced 0 whenever NR42[7:3]=0 (DAC off); in that case trigger still pulses but channel_on stays 0.
REQ-023 If a write and a tick_512 arrive in the same cycle, both SHALL take effect.
REQ-024 If an NR41 write coincides with a length decrement, the load SHALL win.
REQ-025 If a trigger coincides with a decrement to 0, the trigger SHALL win (channel_on=1, length=64).
REQ-026 While apu_enable=0: step held at 0, all ticks and trigger 0, registers and length cleared, channel_on 0, reg_wr ignored.
REQ-027 On re-enable, operation SHALL resume from step 0 on the next tick_512.

Reset
REQ-028 Asserting reset SHALL immediately clear all registers, step, length_remaining, channel_on, trigger and all ticks to 0, including mid-sequence or mid-pulse.
REQ-029 After reset deasserts, the first tick_512 SHALL produce length_tick (step 0).

Configuration
REQ-030 With NOISE_SEQ_SWEEP_EN defined, sweep_tick SHALL operate per REQ-014.
REQ-031 Without NOISE_SEQ_SWEEP_EN, sweep_tick SHALL be tied to 0 and its decode logic absent; the port still exists.

Structure
REQ-032 Shared package apu_pkg SHALL hold:
- register-address enum (NR41..NR44)
- step constants (LEN_STEPS, SWEEP_STEPS, ENV_STEP=7)
- LENGTH_MAX=64
REQ-033 The length counter and channel_on logic SHALL be one sub-module, noise_length_timer; step/tick decode and the register file stay in the top.

Verification
REQ-034 Reset, enable=1, 8 tick_512 strobes -> step sequence 1..7,0; length_tick after ticks 1/3/5/7, sweep_tick after 3/7, envelope_tick after 8.
REQ-035 Write NR42=0xF0, NR41=0x3E, NR44=0xC0, then 4 length_ticks -> length 2 after write, trigger 1 cycle, channel_on=1, then 0 after 2nd length_tick; NR44 reads 0x40.
REQ-036 Write NR42=0x00, then NR44=0x80 -> trigger pulses, channel_on stays 0.
REQ-037 NR44 write (bit7=1) coinciding with length reaching 0 -> channel_on=1, length=64.
REQ-038 Drop apu_enable mid-sequence at step 5 -> all outputs 0, writes ignored; re-enable + tick -> step=1, length_tick pulses.
REQ-039 Build without NOISE_SEQ_SWEEP_EN, run REQ-034 stimulus -> sweep_tick constantly 0, other ticks unchanged.
